// File: rtl/img_loader_pkg.sv
// Shared types and default sizing for the image ping-pong loader.
package img_loader_pkg;

    // Loader FSM: pick an empty bank, stream one image into it, then publish it.
    typedef enum logic [1:0] {
        SELECT = 2'd0,
        FILL   = 2'd1,
        CLOSE  = 2'd2
    } state_t;

    // Which half of the first layer's input SRAM is being addressed.
    typedef enum logic {
        BANK1 = 1'b0,
        BANK2 = 1'b1
    } bank_t;

    // Index of the final word of a default 28x28 image.
    localparam int IMG_LAST_DEF  = 783;
    // Address bits needed to index every word of a default image.
    localparam int CNT_WIDTH_DEF = $clog2(IMG_LAST_DEF + 1);

endpackage

// File: rtl/img_pingpong_loader_if.sv
// Pixel stream from off-chip into the loader.
//
// Handshake: the source holds pix_data/pix_last stable while pix_valid is high;
// a word is transferred on every rising clk edge where pix_valid && pix_ready.
// pix_ready never depends on pix_valid.
interface img_pingpong_loader_if #(
    parameter int W = 16
) ();
    logic [W-1:0] pix_data;
    logic         pix_valid;
    logic         pix_last;
    logic         pix_ready;

    modport master (output pix_data, output pix_valid, output pix_last, input pix_ready);
    modport slave  (input pix_data, input pix_valid, input pix_last, output pix_ready);
endinterface

// File: rtl/pp_bank_tracker.sv
// Owns the two "bank holds a complete image" flags.
// A set from the closing fill always beats a release request for the same bank.
module pp_bank_tracker
    import img_loader_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  bank_t set_bank,
    input  logic  set_valid,
    input  logic  img_request1,
    input  logic  img_request2,
    output logic  full1,
    output logic  full2
);

    logic set1;
    logic set2;

    assign set1 = set_valid && (set_bank == BANK1);
    assign set2 = set_valid && (set_bank == BANK2);

    // Per-bank flag: set has priority, a request clears (a no-op on an empty bank).
    always_ff @(posedge clk) begin
        if (!rst) begin
            full1 <= 1'b0;
            full2 <= 1'b0;
        end else begin
            if (set1)
                full1 <= 1'b1;
            else if (img_request1)
                full1 <= 1'b0;

            if (set2)
                full2 <= 1'b1;
            else if (img_request2)
                full2 <= 1'b0;
        end
    end

endmodule

// File: rtl/img_pingpong_loader.sv
// Streams whole images alternately into the two banks of the first layer's
// input SRAM. Each accepted word is written one cycle later with both
// active-low strobes of the pointed bank low for exactly that cycle.
module img_pingpong_loader
    import img_loader_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int ADDR_WIDTH = CNT_WIDTH_DEF,
    parameter int IMG_WORDS  = IMG_LAST_DEF + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    img_pingpong_loader_if.slave   pix,
    input  logic                   img_request1,
    input  logic                   img_request2,
    output logic [IMG_WIDTH-1:0]   pre_data_offm,
    output logic [ADDR_WIDTH-1:0]  pre_addr_offm,
    output logic                   pre_en1_offm,
    output logic                   pre_en2_offm,
    output logic                   pre_wr1_offm,
    output logic                   pre_wr2_offm,
    output logic                   pre_sram_full1,
    output logic                   pre_sram_full2,
    output logic                   frame_err,
    output state_t                 dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(IMG_WORDS - 1);

    state_t                state;
    state_t                state_n;
    bank_t                 bank_ptr;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  full1;
    logic                  full2;
    logic                  ptr_full;
    logic                  accept;
    logic                  at_last;

    assign pix.pix_ready  = (state == FILL);
    assign accept         = pix.pix_valid && (state == FILL);
    assign at_last        = (cnt == LAST_WORD);
    assign ptr_full       = (bank_ptr == BANK1) ? full1 : full2;
    assign pre_sram_full1 = full1;
    assign pre_sram_full2 = full2;
    assign dbg_state      = state;

    pp_bank_tracker u_tracker (
        .clk          (clk),
        .rst          (rst),
        .set_bank     (bank_ptr),
        .set_valid    (state == CLOSE),
        .img_request1 (img_request1),
        .img_request2 (img_request2),
        .full1        (full1),
        .full2        (full2)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= SELECT;
        else
            state <= state_n;
    end

    // Next state: wait for an empty bank, fill it by word count, close it.
    always_comb begin
        state_n = state;
        case (state)
            SELECT:  if (!ptr_full) state_n = FILL;
            FILL:    if (accept && at_last) state_n = CLOSE;
            CLOSE:   state_n = SELECT;
            default: state_n = SELECT;
        endcase
    end

    // Write strobes, address/data registers, word counter and bank pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_ptr      <= BANK1;
            cnt           <= '0;
            pre_addr_offm <= '0;
            pre_data_offm <= '0;
            pre_en1_offm  <= 1'b1;
            pre_en2_offm  <= 1'b1;
            pre_wr1_offm  <= 1'b1;
            pre_wr2_offm  <= 1'b1;
        end else begin
            pre_en1_offm <= 1'b1;
            pre_en2_offm <= 1'b1;
            pre_wr1_offm <= 1'b1;
            pre_wr2_offm <= 1'b1;
            if (accept) begin
                pre_addr_offm <= cnt;
                pre_data_offm <= pix.pix_data;
                if (bank_ptr == BANK1) begin
                    pre_en1_offm <= 1'b0;
                    pre_wr1_offm <= 1'b0;
                end else begin
                    pre_en2_offm <= 1'b0;
                    pre_wr2_offm <= 1'b0;
                end
                // Hold on the last index; CLOSE clears it for the next image.
                if (!at_last)
                    cnt <= cnt + 1'b1;
            end
            if (state == CLOSE) begin
                cnt      <= '0;
                bank_ptr <= (bank_ptr == BANK1) ? BANK2 : BANK1;
            end
        end
    end

    // Sticky framing error: pix_last must coincide exactly with the last word.
    always_ff @(posedge clk) begin
        if (!rst)
            frame_err <= 1'b0;
        else if (accept && (pix.pix_last != at_last))
            frame_err <= 1'b1;
    end

endmodule
